// File: rtl/tube_collision_scorer.sv
// Per-frame bird-vs-tube/floor collision check, one tube per cycle, with pass scoring.
// Optional ceiling collision via `define CEILING_HIT_EN.
module tube_collision_scorer #(
    parameter int SCREEN_HEIGHT = 768,
    parameter int TUBE_WIDTH    = 120,
    parameter int GAP_HEIGHT    = 400,
    parameter int BIRD_X        = 200,
    parameter int BIRD_SIZE     = 40,
    parameter int SCORE_MAX     = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_rst,
    input  logic        frame_tick,
    input  logic [10:0] bird_y,
    input  logic [10:0] tube_x [2:0],
    input  logic [10:0] gap_y  [2:0],
    output logic        busy,
    output logic        eval_done,
    output logic        hit,
    output logic [9:0]  score
);

    localparam logic [11:0] BX    = 12'(BIRD_X);
    localparam logic [11:0] BS    = 12'(BIRD_SIZE);
    localparam logic [11:0] TW    = 12'(TUBE_WIDTH);
    localparam logic [11:0] GH    = 12'(GAP_HEIGHT);
    localparam logic [11:0] SH    = 12'(SCREEN_HEIGHT);
    localparam logic [9:0]  S_MAX = 10'(SCORE_MAX);

    typedef enum logic [2:0] {IDLE, SNAP, CHK0, CHK1, CHK2, FLOOR, DONE, OVER} state_t;

    state_t      state_q, state_d;
    logic [10:0] bird_q, bird_d;
    logic [10:0] tx_q [2:0];
    logic [10:0] tx_d [2:0];
    logic [10:0] gy_q [2:0];
    logic [10:0] gy_d [2:0];
    logic [2:0]  passed_q, passed_d;
    logic        hit_q, hit_d;
    logic [9:0]  score_q, score_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [1:0]  idx;
    logic [11:0] cur_x, cur_g, by;
    logic        xov, safe, pass, rearm;

    // Select the snapshot of the tube being checked this cycle.
    always_comb begin
        idx   = 2'd0;
        cur_x = {1'b0, tx_q[0]};
        cur_g = {1'b0, gy_q[0]};
        case (state_q)
            CHK1: begin idx = 2'd1; cur_x = {1'b0, tx_q[1]}; cur_g = {1'b0, gy_q[1]}; end
            CHK2: begin idx = 2'd2; cur_x = {1'b0, tx_q[2]}; cur_g = {1'b0, gy_q[2]}; end
            default: ;
        endcase
        by    = {1'b0, bird_q};
        xov   = (cur_x < BX + BS) && (cur_x + TW > BX);
        safe  = (by >= cur_g) && (by + BS <= cur_g + GH);
        pass  = (cur_x + TW <= BX);
        rearm = (cur_x > BX + BS);
    end

    always_comb begin
        state_d  = state_q;
        bird_d   = bird_q;
        tx_d     = tx_q;
        gy_d     = gy_q;
        passed_d = passed_q;
        hit_d    = hit_q;
        score_d  = score_q;
        case (state_q)
            IDLE: if (frame_tick) state_d = SNAP;
            SNAP: begin
                bird_d  = bird_y;
                tx_d    = tube_x;
                gy_d    = gap_y;
                state_d = CHK0;
            end
            CHK0, CHK1, CHK2: begin
                if (xov && !safe) hit_d = 1'b1;
                // Score is frozen the moment hit is set, even by this same tube.
                if (pass && !passed_q[idx] && !hit_d) begin
                    passed_d[idx] = 1'b1;
                    if (score_q < S_MAX) score_d = score_q + 10'd1;
                end else if (rearm) begin
                    passed_d[idx] = 1'b0;
                end
                state_d = (state_q == CHK0) ? CHK1 : (state_q == CHK1) ? CHK2 : FLOOR;
            end
            FLOOR: begin
                if (by + BS > SH) hit_d = 1'b1;
`ifdef CEILING_HIT_EN
                if (bird_q == 11'd0) hit_d = 1'b1;
`endif
                state_d = DONE;
            end
            DONE:    state_d = hit_q ? OVER : IDLE;
            default: state_d = OVER;
        endcase
        if (game_rst) begin
            state_d  = IDLE;
            passed_d = 3'b000;
            hit_d    = 1'b0;
            score_d  = 10'd0;
        end
        busy_d = (state_d != IDLE) && (state_d != OVER);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bird_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                tx_q[i] <= '0;
                gy_q[i] <= '0;
            end
            passed_q <= '0;
            hit_q    <= 1'b0;
            score_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bird_q   <= bird_d;
            tx_q     <= tx_d;
            gy_q     <= gy_d;
            passed_q <= passed_d;
            hit_q    <= hit_d;
            score_q  <= score_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign eval_done = done_q;
    assign hit       = hit_q;
    assign score     = score_q;

endmodule

// File: tb/tb_tube_collision_scorer.sv
// Scoreboard bench for tube_collision_scorer: frames push expected {hit,score},
// a monitor pops and compares on every eval_done pulse.
module tb_tube_collision_scorer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        game_rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic [10:0] bird_y;
    logic [10:0] tube_x [2:0];
    logic [10:0] gap_y  [2:0];
    logic        busy, eval_done, hit;
    logic [9:0]  score;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       hit;
        logic [9:0] score;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    tube_collision_scorer dut (
        .clk(clk), .rst(rst), .game_rst(game_rst), .frame_tick(frame_tick),
        .bird_y(bird_y), .tube_x(tube_x), .gap_y(gap_y),
        .busy(busy), .eval_done(eval_done), .hit(hit), .score(score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && eval_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_eval_done: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("eval_hit", int'(hit), int'(mon_e.hit));
                chk("eval_score", int'(score), int'(mon_e.score));
            end
        end
    end

    task automatic set_tubes(input int x0, input int x1, input int x2);
        tube_x[0] = 11'(x0);
        tube_x[1] = 11'(x1);
        tube_x[2] = 11'(x2);
    endtask

    // Issue one frame and wait (bounded) for its eval_done.
    task automatic frame(input bit eh, input int es);
        bit seen;
        exp_q.push_back('{hit: eh, score: 10'(es)});
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (eval_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("eval_done_timeout", 0, 1);
    endtask

    task automatic pulse_game_rst;
        @(posedge clk); #1 game_rst = 1'b1;
        @(posedge clk); #1 game_rst = 1'b0;
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(name, int'(busy), 0);
        end
    endtask

    initial begin
        int s;
        bird_y = 11'd300;
        for (int i = 0; i < 3; i++) gap_y[i] = 11'd200;
        set_tubes(1000, 1400, 1800);
        #12 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_hit", int'(hit), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_done", int'(eval_done), 0);

        // busy for T+1..T+6, eval_done only at T+6
        exp_q.push_back('{hit: 1'b0, score: 10'd0});
        @(posedge clk); #1 frame_tick = 1'b1;
        @(negedge clk);
        chk("busy_t0", int'(busy), 0);
        @(posedge clk); #1 frame_tick = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("busy_timing", int'(busy), (k <= 6) ? 1 : 0);
            chk("done_timing", int'(eval_done), (k == 6) ? 1 : 0);
        end

        // Tubes all to the right: nothing happens
        set_tubes(500, 900, 1300);
        frame(1'b0, 0);

        // Gap edges: top touch safe, bottom touch safe, one past bottom hits
        set_tubes(200, 900, 1300);
        bird_y = 11'd200; frame(1'b0, 0);
        bird_y = 11'd560; frame(1'b0, 0);
        bird_y = 11'd561; frame(1'b1, 0);
        pulse_game_rst();
        @(negedge clk);
        chk("game_rst_hit", int'(hit), 0);

        // Above the gap while overlapping: hit, then ticks in OVER are ignored
        set_tubes(180, 900, 1300);
        bird_y = 11'd150; frame(1'b1, 0);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        idle_check("over_ignores_tick", 10);
        chk("over_hit_sticky", int'(hit), 1);
        pulse_game_rst();

        // Floor boundary
        set_tubes(1000, 1400, 1800);
        bird_y = 11'd728; frame(1'b0, 0);
        bird_y = 11'd729; frame(1'b1, 0);
        pulse_game_rst();

        // Scoring: pass, no double count, re-arm, pass again
        bird_y = 11'd300;
        set_tubes(70, 1000, 1400);   frame(1'b0, 1);
        frame(1'b0, 1);
        set_tubes(1500, 1000, 1400); frame(1'b0, 1);
        set_tubes(70, 1000, 1400);   frame(1'b0, 2);
        set_tubes(0, 1000, 1400);    frame(1'b0, 2);

        // Hit in CHK0 freezes a pass of tube1 in CHK1
        set_tubes(180, 70, 1400);
        bird_y = 11'd150; frame(1'b1, 2);
        pulse_game_rst();
        @(negedge clk);
        chk("rst_score", int'(score), 0);

        // game_rst while CHK1 is active abandons the evaluation
        bird_y = 11'd300;
        set_tubes(70, 1000, 1400);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 game_rst = 1'b1;
        @(negedge clk);
        chk("chk1_busy", int'(busy), 1);
        chk("chk1_score_before_rst", int'(score), 1);
        @(posedge clk); #1 game_rst = 1'b0;
        idle_check("abandoned_eval", 8);
        chk("abandon_score", int'(score), 0);
        chk("abandon_hit", int'(hit), 0);

        // game_rst with frame_tick: tick dropped
        @(posedge clk); #1 game_rst = 1'b1; frame_tick = 1'b1;
        @(posedge clk); #1 game_rst = 1'b0; frame_tick = 1'b0;
        idle_check("rst_tick_collision", 8);

        // Saturation: three passes per frame until pinned at 999
        s = 0;
        for (int i = 0; i < 336; i++) begin
            set_tubes(70, 70, 70);
            s = (s + 3 > 999) ? 999 : s + 3;
            frame(1'b0, s);
            set_tubes(1500, 1500, 1500);
            frame(1'b0, s);
        end
        chk("saturated", int'(score), 999);

        // Async rst mid-evaluation clears everything immediately
        set_tubes(70, 70, 70);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_score", int'(score), 0);
        chk("async_hit", int'(hit), 0);
        chk("async_done", int'(eval_done), 0);
        @(posedge clk); #1 rst = 1'b0;
        idle_check("after_async", 4);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
